// File: rtl/vend_pkg.sv
// Shared types and constants for the vending-machine front end:
// command encoding, switch bit positions and the conditioner FSM states.
package vend_pkg;

   typedef logic [2:0] cmd_t;

   localparam cmd_t CMD_NONE   = 3'd0;
   localparam cmd_t CMD_HALF   = 3'd1;
   localparam cmd_t CMD_ONE    = 3'd2;
   localparam cmd_t CMD_COLA   = 3'd3;
   localparam cmd_t CMD_TEA    = 3'd4;
   localparam cmd_t CMD_MILK   = 3'd5;
   localparam cmd_t CMD_SUPPLY = 3'd6;
   localparam cmd_t CMD_RETURN = 3'd7;

   localparam int NUM_SW    = 7;
   localparam int SW_HALF   = 0;
   localparam int SW_ONE    = 1;
   localparam int SW_COLA   = 2;
   localparam int SW_TEA    = 3;
   localparam int SW_MILK   = 4;
   localparam int SW_SUPPLY = 5;
   localparam int SW_RETURN = 6;

   localparam logic [1:0] ST_WAIT_PRESS   = 2'd0;
   localparam logic [1:0] ST_EMIT         = 2'd1;
   localparam logic [1:0] ST_WAIT_RELEASE = 2'd2;

   // Switch positions are laid out so that each command code is index + 1.
   function automatic cmd_t sw_encode(input logic [NUM_SW-1:0] sw);
      cmd_t code;
      code = CMD_NONE;
      for (int i = 0; i < NUM_SW; i++) begin
         if (sw[i]) code = cmd_t'(i + 1);
      end
      return code;
   endfunction

   function automatic logic sw_onehot(input logic [NUM_SW-1:0] sw);
      return $onehot(sw);
   endfunction

endpackage

// File: rtl/vend_debounce.sv
// Two-flop synchroniser and stable-count debouncer for the action button;
// press_evt pulses for one cycle when the debounced level rises.
module vend_debounce #(
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter int CNT_W           = 20
) (
   input  logic clk,
   input  logic rst,
   input  logic raw,
   output logic act_db,
   output logic press_evt
);

   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [1:0]       sync;
   logic             act_s;
   logic [CNT_W-1:0] cnt;

   assign act_s = sync[1];

   // act_db resets high so a button held through reset must be released first.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync      <= 2'b00;
         cnt       <= '0;
         act_db    <= 1'b1;
         press_evt <= 1'b0;
      end else begin
         sync      <= {sync[0], raw};
         press_evt <= 1'b0;
         if (act_s == act_db) begin
            cnt <= '0;
         end else if (cnt == CNT_MAX) begin
            act_db    <= ~act_db;
            cnt       <= '0;
            press_evt <= ~act_db;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/vend_cmd_conditioner.sv
// Command front end: synchronises switches, validates each clean press
// and offers one encoded command on a valid/ready handshake.
module vend_cmd_conditioner
   import vend_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter int CNT_W           = 20
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       halfyuan,
   input  logic       oneyuan,
   input  logic       sell_cola,
   input  logic       sell_tea,
   input  logic       sell_milk,
   input  logic       supply,
   input  logic       coin_return,
   input  logic       action,
   output logic       cmd_valid,
   output logic [2:0] cmd_code,
   input  logic       cmd_ready,
   output logic       err_pulse,
   output logic       busy
);

   logic [NUM_SW-1:0] sw_raw;
   logic [NUM_SW-1:0] sw_m;
   logic [NUM_SW-1:0] sw_s;
   logic [1:0]        state;
   logic              act_db;
   logic              press_evt;

   assign sw_raw = {coin_return, supply, sell_milk, sell_tea,
                    sell_cola, oneyuan, halfyuan};

   vend_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
   ) u_debounce (
      .clk      (clk),
      .rst      (rst),
      .raw      (action),
      .act_db   (act_db),
      .press_evt(press_evt)
   );

   assign busy = (state != ST_WAIT_PRESS);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sw_m      <= '0;
         sw_s      <= '0;
         state     <= ST_WAIT_RELEASE;
         cmd_valid <= 1'b0;
         cmd_code  <= CMD_NONE;
         err_pulse <= 1'b0;
      end else begin
         sw_m      <= sw_raw;
         sw_s      <= sw_m;
         err_pulse <= 1'b0;
         unique case (state)
            ST_WAIT_PRESS: begin
               if (press_evt) begin
                  if (sw_onehot(sw_s)) begin
                     cmd_code  <= sw_encode(sw_s);
                     cmd_valid <= 1'b1;
                     state     <= ST_EMIT;
                  end else begin
                     err_pulse <= 1'b1;
                     state     <= ST_WAIT_RELEASE;
                  end
               end
            end
            ST_EMIT: begin
               if (cmd_ready) begin
                  cmd_valid <= 1'b0;
                  cmd_code  <= CMD_NONE;
                  state     <= ST_WAIT_RELEASE;
               end
            end
            ST_WAIT_RELEASE: begin
               if (!act_db) state <= ST_WAIT_PRESS;
            end
            default: state <= ST_WAIT_RELEASE;
         endcase
      end
   end

endmodule

// File: tb/tb_vend_cmd_conditioner.sv
// Directed bench for vend_cmd_conditioner with an 8-cycle debounce:
// a switch-pattern table plus hand-written multi-cycle sequences.
module tb_vend_cmd_conditioner;

   logic       clk;
   logic       rst;
   logic [6:0] sw;
   logic       action;
   logic       cmd_ready;
   logic       cmd_valid;
   logic [2:0] cmd_code;
   logic       err_pulse;
   logic       busy;

   int errors;
   int checks;

   typedef struct {
      logic [6:0] sw;
      logic [2:0] code;
      logic       err;
   } vec_t;

   vec_t vecs[10];

   vend_cmd_conditioner #(
      .DEBOUNCE_CYCLES(8),
      .CNT_W          (4)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .halfyuan   (sw[0]),
      .oneyuan    (sw[1]),
      .sell_cola  (sw[2]),
      .sell_tea   (sw[3]),
      .sell_milk  (sw[4]),
      .supply     (sw[5]),
      .coin_return(sw[6]),
      .action     (action),
      .cmd_valid  (cmd_valid),
      .cmd_code   (cmd_code),
      .cmd_ready  (cmd_ready),
      .err_pulse  (err_pulse),
      .busy       (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic press_observe(input int window, output int lat,
                                output int vcnt, output int ecnt,
                                output logic [2:0] code);
      action = 1'b1;
      lat    = -1;
      vcnt   = 0;
      ecnt   = 0;
      code   = 3'd0;
      for (int i = 1; i <= window; i++) begin
         step();
         if ((cmd_valid || err_pulse) && lat < 0) lat = i;
         if (cmd_valid) begin
            if (vcnt == 0) code = cmd_code;
            vcnt++;
         end
         if (err_pulse) ecnt++;
      end
   endtask

   task automatic release_wait(input string name);
      int done;
      action = 1'b0;
      done   = 0;
      for (int i = 0; i < 40 && done == 0; i++) begin
         step();
         if (!busy) done = 1;
      end
      check(name, done, 1);
   endtask

   initial begin
      int lat, vcnt, ecnt, first_low, badcode, xfer;
      logic [2:0] code;

      errors    = 0;
      checks    = 0;
      rst       = 1'b1;
      sw        = 7'd0;
      action    = 1'b0;
      cmd_ready = 1'b0;

      vecs[0] = '{7'b0000001, 3'd1, 1'b0};
      vecs[1] = '{7'b0000010, 3'd2, 1'b0};
      vecs[2] = '{7'b0000100, 3'd3, 1'b0};
      vecs[3] = '{7'b0001000, 3'd4, 1'b0};
      vecs[4] = '{7'b0010000, 3'd5, 1'b0};
      vecs[5] = '{7'b0100000, 3'd6, 1'b0};
      vecs[6] = '{7'b1000000, 3'd7, 1'b0};
      vecs[7] = '{7'b0000101, 3'd0, 1'b1};
      vecs[8] = '{7'b0000000, 3'd0, 1'b1};
      vecs[9] = '{7'b1111111, 3'd0, 1'b1};

      step();
      step();
      check("rst_valid", int'(cmd_valid), 0);
      check("rst_code", int'(cmd_code), 0);
      check("rst_err", int'(err_pulse), 0);
      check("rst_busy", int'(busy), 1);

      // act_db falls at edge 8 after release, busy one edge later.
      rst       = 1'b0;
      first_low = -1;
      vcnt      = 0;
      ecnt      = 0;
      for (int i = 1; i <= 20; i++) begin
         step();
         if (!busy && first_low < 0) first_low = i;
         if (cmd_valid) vcnt++;
         if (err_pulse) ecnt++;
      end
      check("boot_busy_fall", first_low, 9);
      check("boot_valid", vcnt, 0);
      check("boot_err", ecnt, 0);

      cmd_ready = 1'b1;
      for (int v = 0; v < 10; v++) begin
         sw = vecs[v].sw;
         press_observe(25, lat, vcnt, ecnt, code);
         check($sformatf("tab%0d_lat", v), lat, 11);
         check($sformatf("tab%0d_vcnt", v), vcnt, vecs[v].err ? 0 : 1);
         check($sformatf("tab%0d_err", v), ecnt, int'(vecs[v].err));
         check($sformatf("tab%0d_code", v), int'(code), int'(vecs[v].code));
         release_wait($sformatf("tab%0d_rel", v));
         check($sformatf("tab%0d_idle", v), int'(cmd_code), 0);
      end

      // Glitches on action shorter than the debounce window.
      sw = 7'b0001000;
      for (int g = 0; g < 3; g++) begin
         action = 1'b1;
         repeat (3) step();
         action = 1'b0;
         repeat (3) step();
      end
      press_observe(25, lat, vcnt, ecnt, code);
      check("glitch_lat", lat, 11);
      check("glitch_vcnt", vcnt, 1);
      check("glitch_err", ecnt, 0);
      check("glitch_code", int'(code), 4);
      release_wait("glitch_rel");

      // Backpressure: command held stable while switches and button change.
      sw        = 7'b0000010;
      cmd_ready = 1'b0;
      action    = 1'b1;
      repeat (11) step();
      check("bp_first_valid", int'(cmd_valid), 1);
      vcnt    = 0;
      badcode = 0;
      xfer    = 0;
      for (int c = 0; c < 12; c++) begin
         cmd_ready = (c >= 5);
         if (c == 1) begin
            sw[4]  = 1'b1;
            action = 1'b0;
         end
         if (c == 3) begin
            sw[4]  = 1'b0;
            action = 1'b1;
         end
         #1;
         if (cmd_valid) begin
            vcnt++;
            if (cmd_code != 3'd2) badcode++;
            if (cmd_ready) xfer++;
         end
         step();
      end
      check("bp_vcnt", vcnt, 6);
      check("bp_badcode", badcode, 0);
      check("bp_xfer", xfer, 1);
      cmd_ready = 1'b0;
      release_wait("bp_rel");

      // Reset during EMIT with the button still held afterwards.
      sw     = 7'b0100000;
      action = 1'b1;
      repeat (11) step();
      check("rstemit_valid", int'(cmd_valid), 1);
      check("rstemit_code", int'(cmd_code), 6);
      #3;
      rst = 1'b1;
      #1;
      check("rstemit_async_valid", int'(cmd_valid), 0);
      check("rstemit_async_code", int'(cmd_code), 0);
      step();
      step();
      rst  = 1'b0;
      vcnt = 0;
      ecnt = 0;
      for (int i = 0; i < 30; i++) begin
         step();
         if (cmd_valid) vcnt++;
         if (err_pulse) ecnt++;
      end
      check("held_vcnt", vcnt, 0);
      check("held_err", ecnt, 0);
      check("held_busy", int'(busy), 1);
      release_wait("held_rel");
      cmd_ready = 1'b1;
      press_observe(25, lat, vcnt, ecnt, code);
      check("repress_lat", lat, 11);
      check("repress_vcnt", vcnt, 1);
      check("repress_code", int'(code), 6);
      release_wait("repress_rel");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
